kf8237_timing_and_control: RTL

KF8237_TIMING_AND_CONTROL -- requirements
Module: kf8237_timing_and_control

---
 rtl/kf8237_timing_and_control.sv | 121 ++++++++++++
 1 files changed

// File: rtl/kf8237_timing_and_control.sv
// KF8237 DMA timing and control: request/HLDA handshake, S-state sequencing,
// bus strobes and terminal-count status for the active channel.
module kf8237_timing_and_control (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_clock_posedge,
    input  logic       cpu_clock_negedge,
    input  logic       master_clear,
    input  logic [3:0] encoded_dma,
    input  logic       hold_acknowledge,
    input  logic       ready,
    input  logic [1:0] transfer_mode,
    input  logic [1:0] transfer_type,
    input  logic       autoinitialize,
    input  logic       underflow,
    input  logic       update_high_address,
    output logic       hold_request,
    output logic [3:0] dma_acknowledge,
    output logic [3:0] transfer_register_select,
    output logic       next_word,
    output logic       initialize_current_register,
    output logic [3:0] terminal_count,
    output logic       end_of_process,
    output logic       address_enable,
    output logic       address_strobe,
    output logic       io_read_n,
    output logic       io_write_n,
    output logic       memory_read_n,
    output logic       memory_write_n
);

    typedef enum logic [2:0] {SI, S0, S1, S2, S3, SW, S4} state_t;

    state_t state;
    state_t state_next;
    logic   clear;
    logic   underflow_q;
    logic   update_high_q;
    logic   s4_exit;
    logic   tc_exit;
    logic   is_block;
    logic   is_demand;
    logic   is_write;
    logic   is_read;
    logic   still_requested;
    logic   in_transfer;
    logic   read_phase;
    logic   write_phase;

    assign clear           = reset | master_clear;
    assign is_block        = (transfer_mode == 2'b10);
    assign is_demand       = (transfer_mode == 2'b00);
    assign is_write        = (transfer_type == 2'b01);
    assign is_read         = (transfer_type == 2'b10);
    assign still_requested = |(encoded_dma & transfer_register_select);
    assign s4_exit         = ~clear & cpu_clock_posedge & (state == S4);
    assign tc_exit         = s4_exit & underflow_q;

    // Underflow/high-address flags change once the count commits, so inside S4
    // they are captured on the DMA falling edge and held until the exit.
    always_ff @(posedge clock) begin
        if (clear) begin
            state                    <= SI;
            transfer_register_select <= 4'b0000;
            terminal_count           <= 4'b0000;
            underflow_q              <= 1'b0;
            update_high_q            <= 1'b0;
        end else begin
            if (cpu_clock_posedge)
                state <= state_next;
            if (cpu_clock_posedge && state == SI && encoded_dma != 4'b0000)
                transfer_register_select <= encoded_dma;
            if (tc_exit)
                terminal_count <= terminal_count | transfer_register_select;
            if (state != S4 || cpu_clock_negedge) begin
                underflow_q   <= underflow;
                update_high_q <= update_high_address;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SI: if (encoded_dma != 4'b0000) state_next = S0;
            S0: if (hold_acknowledge) state_next = S1;
            S1: state_next = S2;
            S2: state_next = S3;
            S3, SW: state_next = ready ? S4 : SW;
            S4: begin
                if (underflow_q)
                    state_next = SI;
                else if (is_block || (is_demand && still_requested))
                    state_next = update_high_q ? S1 : S2;
                else
                    state_next = SI;
            end
            default: state_next = SI;
        endcase
    end

    always_comb begin
        in_transfer = (state == S1) || (state == S2) || (state == S3)
                   || (state == SW) || (state == S4);
        write_phase = (state == S3) || (state == SW) || (state == S4);
        read_phase  = (state == S2) || write_phase;

        hold_request                = (state != SI);
        address_enable              = in_transfer;
        address_strobe              = (state == S1);
        next_word                   = (state == S4);
        dma_acknowledge             = in_transfer ? transfer_register_select : 4'b0000;
        end_of_process              = tc_exit;
        initialize_current_register = tc_exit & autoinitialize;
        io_read_n                   = ~(is_write & read_phase);
        memory_write_n              = ~(is_write & write_phase);
        memory_read_n               = ~(is_read & read_phase);
        io_write_n                  = ~(is_read & write_phase);
    end

endmodule
